// File: rtl/reg_wb_arbiter.sv
// ALU/load writeback arbiter for reg_file with pending-write scoreboard; grant is combinational, write lands one cycle later.
// The loser holds until granted; `REG_WB_ROUND_ROBIN_EN alternates conflict winners, otherwise MEM always wins.
package reg_wb_pkg;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [31:0] arch_reg;

    typedef struct packed {
        logic                      write_enable;
        logic [REG_ADDR_WIDTH-1:0] addr_rd;
    } reg_file_write_params_t;
endpackage

module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int NUM_REGS = 2**REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_addr_rd,
    input  arch_reg                   alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_addr_rd,
    input  arch_reg                   mem_data,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_addr_rd,
    output reg_file_write_params_t    write_params,
    output arch_reg                   data_rd,
    output logic [NUM_REGS-1:0]       busy
);

    logic                      mem_wins;
    logic                      grant_alu;
    logic                      grant_mem;
    reg_file_write_params_t    wp_q;
    reg_file_write_params_t    wp_d;
    arch_reg                   data_q;
    arch_reg                   data_d;
    logic [NUM_REGS-1:0]       pending_q;
    logic [NUM_REGS-1:0]       pending_d;
    logic                      issue_hits_busy;

`ifdef REG_WB_ROUND_ROBIN_EN
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } last_grant_t;

    logic        conflict;
    last_grant_t last_grant_q;
    last_grant_t last_grant_d;

    assign conflict = alu_valid && mem_valid;
    assign mem_wins = (last_grant_q == LAST_ALU);

    // Pointer moves only when both requesters compete.
    always_comb begin
        last_grant_d = last_grant_q;
        if (conflict && !reset) begin
            last_grant_d = mem_wins ? LAST_MEM : LAST_ALU;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= LAST_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign mem_wins = 1'b1;
`endif

    always_comb begin
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (!reset) begin
            grant_mem = mem_valid && (!alu_valid || mem_wins);
            grant_alu = alu_valid && !grant_mem;
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // x0 writes still take the grant but never raise write_enable.
    always_comb begin
        wp_d.write_enable = 1'b0;
        wp_d.addr_rd      = wp_q.addr_rd;
        data_d            = data_q;
        if (grant_alu) begin
            wp_d.addr_rd      = alu_addr_rd;
            wp_d.write_enable = (alu_addr_rd != '0);
            data_d            = alu_data;
        end else if (grant_mem) begin
            wp_d.addr_rd      = mem_addr_rd;
            wp_d.write_enable = (mem_addr_rd != '0);
            data_d            = mem_data;
        end
    end

    // Clear first so a same-edge claim of the retiring register survives.
    always_comb begin
        pending_d = pending_q;
        if (wp_q.write_enable) begin
            pending_d[wp_q.addr_rd] = 1'b0;
        end
        if (issue_valid && (issue_addr_rd != '0)) begin
            pending_d[issue_addr_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            wp_q      <= wp_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign write_params = wp_q;
    assign data_rd      = data_q;
    assign busy         = pending_q;

    assign issue_hits_busy = issue_valid && (issue_addr_rd != '0) && pending_q[issue_addr_rd]
                             && !(wp_q.write_enable && (wp_q.addr_rd == issue_addr_rd));

    a_issue_not_busy: assert property (@(posedge clock) disable iff (reset) !issue_hits_busy)
        else $error("issue to a register with a write already pending");

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Shares the register file's single write port between the ALU writeback path and the load/memory writeback path. It also keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards. It sits between the execute/memory stages and `reg_file`. It drives that block's `write_params` and `data_rd` from a registered output stage.

## Interface
Parameters:
- `NUM_REGS`, default `2**REG_ADDR_WIDTH` (32): scoreboard depth; must equal the register file size.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU request granted this cycle.
- `alu_addr_rd`  in  `REG_ADDR_WIDTH`  ALU destination register.
- `alu_data`  in  32 (`arch_reg`)  ALU result.
- `mem_valid`  in  1  load writeback request.
- `mem_ready`  out  1  load request granted this cycle.
- `mem_addr_rd`  in  `REG_ADDR_WIDTH`  load destination register.
- `mem_data`  in  32 (`arch_reg`)  load data.
- `issue_valid`  in  1  decode issues an instruction that writes `issue_addr_rd`.
- `issue_addr_rd`  in  `REG_ADDR_WIDTH`  destination register being claimed.
- `write_params`  out  `reg_file_write_params_t`  to `reg_file`: `write_enable` and `addr_rd`.
- `data_rd`  out  32 (`arch_reg`)  to `reg_file`.
- `busy`  out  `NUM_REGS`  pending-write bitmap; bit 0 is always 0.

## Operation
- **Arbitration:** combinational, at most one grant per cycle. `alu_ready`/`mem_ready` are asserted only when the corresponding valid is high and that requester wins.
  - A single valid requester always wins.
  - On conflict the winner is chosen per Configuration.
  - A requester holds its valid and payload stable until granted; the bench checks this.
- **Output stage:** on a grant, the winner's `addr_rd` and data are registered into `write_params.addr_rd` and `data_rd`. `write_params.write_enable` is registered as 1 if `addr_rd != 0`, and 0 otherwise.
  - With no grant, `write_enable` is registered as 0.
  - `addr_rd` and `data_rd` keep their previous values.
- **Requests to x0:** accepted and consume the grant, but produce no write and do not touch the scoreboard.
- **Scoreboard:** a `NUM_REGS`-bit register `pending`, with `busy = pending`.
  - **Set:** `issue_valid && issue_addr_rd != 0` sets `pending[issue_addr_rd]` at the clock edge.
  - **Clear:** on the edge where the output stage has `write_enable=1`, `pending[write_params.addr_rd]` is cleared.
  - **Set and clear of the same register on the same edge:** set wins (a new producer is in flight).
  - **Issue to an already-busy register:** protocol violation. Decode must stall on `busy[rd]`. The implementation includes a simulation assertion for it; the bit stays 1.
  - `pending[0]` is hard-wired to 0.
- **Reset:** at any time, clears `pending`, `write_enable`, `addr_rd`, `data_rd` and the round-robin pointer. In-flight writes are dropped.

## Timing
- Request granted in cycle N → `write_enable` high in cycle N+1 → register file updated at the end of N+1 → `reg_file` reads it from cycle N+2.
- `busy[rd]` rises in the cycle after the issue edge. It falls in cycle N+2 for a grant in cycle N, aligned with data visibility; there is no bypass.
- Throughput: one write per cycle. Under continuous contention the losing requester waits one or more cycles.
- Reset values:
  - `alu_ready`, `mem_ready`: 0 while `reset` is asserted; combinational afterwards.
  - `write_params`: `{0, 0}`.
  - `data_rd`: 0.
  - `busy`: 0.
  - Round-robin pointer: "last = ALU".

## Configuration
- `REG_WB_ROUND_ROBIN_EN` defined: on conflict, grant goes to the requester that did not win the most recent conflict.
  - A 1-bit `last_grant` register updates only on conflict cycles.
  - It resets to ALU, so the first conflict after reset grants MEM.
- Not defined: fixed priority, MEM always beats ALU. There is no pointer register.

## Test plan
- **Single writes:** ALU writes x5=0x1234 in cycle 1 → `write_enable=1`, `addr_rd=5`, `data_rd=0x1234` in cycle 2. Then MEM writes x7=0xDEAD with the same latency.
- **Conflict:** both valid with ALU x3=0x11 and MEM x4=0x22, held.
  - With the macro defined: MEM granted first and ALU one cycle later; under 4 more cycles of continuous conflict, grants alternate.
  - Without the macro: MEM always wins and ALU waits.
- **Scoreboard lifecycle:** issue x9 at cycle 1 → `busy[9]=1` from cycle 2. ALU write x9 granted at cycle 4 → `busy[9]=0` from cycle 6.
- **Simultaneous set and clear:** output stage writes x9 while `issue_valid` claims x9 on the same edge → `busy[9]` stays 1.
- **x0 handling:** ALU write x0=0xFFFF → `alu_ready=1` and the next-cycle `write_enable=0`. `issue_addr_rd=0` → `busy[0]` stays 0.
- **Reset mid-operation:** with `busy=0x0000_0600` and a granted write pending output, assert `reset` asynchronously → immediately `busy=0` and `write_enable=0`. After release, the first conflict grants MEM.
